seq_divider: RTL and testbench

//  Sequential unsigned restoring divider; the inverse of the MAC datapath's

---
 rtl/seq_divider.sv | 122 ++++++++++++
 tb/tb_seq_divider.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// The trial subtraction is a ripple of full-subtractor bit slices.

module seq_divider_sub_slice (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module seq_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state;
  logic [W-1:0]  r, q, d;
  logic [CW-1:0] cnt;

  // Partial remainder shifted left with the next dividend bit; needs W+1 bits
  // because 2R+1 can exceed W bits when R is close to D.
  logic [W:0]    rs, dw, t;
  logic [W+1:0]  bw;
  logic          no_borrow;
  logic [W-1:0]  r_nxt, q_nxt;

  assign rs    = {r, q[W-1]};
  assign dw    = {1'b0, d};
  assign bw[0] = 1'b0;

  for (genvar i = 0; i <= W; i++) begin : g_slice
    seq_divider_sub_slice u_slice (
      .a    (rs[i]),
      .b    (dw[i]),
      .bin  (bw[i]),
      .diff (t[i]),
      .bout (bw[i+1])
    );
  end

  assign no_borrow = ~bw[W+1];
  assign r_nxt     = no_borrow ? t[W-1:0] : rs[W-1:0];
  assign q_nxt     = {q[W-2:0], no_borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            q    <= dividend;
            d    <= divisor;
            r    <= '0;
            cnt  <= '0;
            busy <= 1'b1;
            if (divisor == '0) begin
              state       <= FIN;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          r   <= r_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          // Results load from the final iteration's next-state values so
          // they appear together with done.
          if (cnt == CW'(W - 1)) begin
            state       <= FIN;
            done        <= 1'b1;
            quotient    <= q_nxt;
            remainder   <= r_nxt;
            div_by_zero <= 1'b0;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int total = 0;
  int bad = 0;

  seq_divider #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division; divisor 0 yields all ones / dividend.
  function automatic void model(input logic [W-1:0] n, input logic [W-1:0] dv,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    if (dv == 0) begin
      q = '1; r = n; z = 1'b1;
    end else begin
      q = W'(int'(n) / int'(dv)); r = W'(int'(n) % int'(dv)); z = 1'b0;
    end
  endfunction

  // Issues one request in the next IDLE negedge window and waits for done.
  // lat counts cycles from the accepting edge to the cycle where done is seen.
  task automatic run_div(input logic [W-1:0] n, input logic [W-1:0] dv,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output int lat, output int unstable,
                         output int busylow);
    logic [W-1:0] q0, r0;
    @(negedge clk);
    start = 1'b1; dividend = n; divisor = dv;
    q0 = quotient; r0 = remainder;
    @(negedge clk);
    start = 1'b0;
    lat = 1; unstable = 0; busylow = 0;
    while (done !== 1'b1 && lat < 64) begin
      if (busy !== 1'b1) busylow++;
      if (quotient !== q0 || remainder !== r0) unstable++;
      @(negedge clk);
      lat++;
    end
    q = quotient; r = remainder; z = div_by_zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] n[3] = '{16'd100, 16'hFFFF, 16'h8000};
    logic [W-1:0] dv[3] = '{16'd7, 16'h0001, 16'hFFFF};
    logic [W-1:0] eq[3] = '{16'd14, 16'hFFFF, 16'h0000};
    logic [W-1:0] er[3] = '{16'd2, 16'h0000, 16'h8000};
    logic [W-1:0] q, r;
    logic z;
    int lat, us, bl;
    for (int i = 0; i < 3; i++) begin
      run_div(n[i], dv[i], q, r, z, lat, us, bl);
      total++;
      if (q !== eq[i] || r !== er[i] || z !== 1'b0 || lat != W + 1) begin
        bad++;
        $display("FAIL directed_%0d: got q=%0d r=%0d dbz=%b lat=%0d, want q=%0d r=%0d dbz=0 lat=%0d",
                 i, q, r, z, lat, eq[i], er[i], W + 1);
      end
      total++;
      if (bl != 0) begin
        bad++;
        $display("FAIL directed_busy_%0d: busy low %0d cycles, want 0", i, bl);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r;
    logic z;
    int lat, us, bl;
    run_div(16'd5, 16'd0, q, r, z, lat, us, bl);
    total++;
    if (q !== 16'hFFFF || r !== 16'd5 || z !== 1'b1 || lat != 1) begin
      bad++;
      $display("FAIL div_zero: got q=%h r=%0d dbz=%b lat=%0d, want q=ffff r=5 dbz=1 lat=1",
               q, r, z, lat);
    end
    @(negedge clk);
    total++;
    if (div_by_zero !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL div_zero_after: got dbz=%b done=%b busy=%b, want 1 0 0",
               div_by_zero, done, busy);
    end
    run_div(16'd9, 16'd3, q, r, z, lat, us, bl);
    total++;
    if (q !== 16'd3 || r !== 16'd0 || z !== 1'b0 || lat != W + 1) begin
      bad++;
      $display("FAIL div_zero_clear: got q=%0d r=%0d dbz=%b lat=%0d, want q=3 r=0 dbz=0 lat=%0d",
               q, r, z, lat, W + 1);
    end
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    int first = -1;
    logic [W-1:0] q = '0, r = '0;
    @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 16'd9;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = (c == 5);
      if (c == 5) begin dividend = 16'd7; divisor = 16'd7; end
      if (done === 1'b1) begin
        dones++;
        if (first < 0) begin first = c; q = quotient; r = remainder; end
      end
    end
    start = 1'b0;
    total++;
    if (dones != 1 || first != W + 1) begin
      bad++;
      $display("FAIL start_ignored_done: got %0d pulses first at %0d, want 1 at %0d",
               dones, first, W + 1);
    end
    total++;
    if (q !== 16'd111 || r !== 16'd1) begin
      bad++;
      $display("FAIL start_ignored_result: got q=%0d r=%0d, want q=111 r=1", q, r);
    end
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    logic [W-1:0] q, r;
    logic z;
    int lat, us, bl;
    @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 16'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      bad++;
      $display("FAIL reset_abort_outputs: got busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL reset_abort_nodone: got %0d active cycles, want 0", dones);
    end
    run_div(16'd50, 16'd8, q, r, z, lat, us, bl);
    total++;
    if (q !== 16'd6 || r !== 16'd2 || z !== 1'b0 || lat != W + 1) begin
      bad++;
      $display("FAIL reset_abort_after: got q=%0d r=%0d dbz=%b lat=%0d, want q=6 r=2 dbz=0 lat=%0d",
               q, r, z, lat, W + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q, r;
    logic z;
    int lat, us, bl;
    run_div(16'd200, 16'd11, q, r, z, lat, us, bl);
    run_div(16'd300, 16'd13, q, r, z, lat, us, bl);
    total++;
    if (q !== 16'd23 || r !== 16'd1 || lat != W + 1) begin
      bad++;
      $display("FAIL back_to_back: got q=%0d r=%0d lat=%0d, want q=23 r=1 lat=%0d",
               q, r, lat, W + 1);
    end
    total++;
    if (us != 0) begin
      bad++;
      $display("FAIL back_to_back_hold: outputs changed in %0d cycles before done, want 0", us);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] pick[6] = '{16'h0000, 16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF, 16'h0002};
    logic [W-1:0] n, dv, q, r, mq, mr;
    logic z, mz;
    int lat, us, bl;
    for (int i = 0; i < 2000; i++) begin
      n  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : W'($urandom);
      dv = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : W'($urandom);
      if ($urandom_range(0, 3) == 0) dv = W'($urandom_range(1, 300));
      model(n, dv, mq, mr, mz);
      run_div(n, dv, q, r, z, lat, us, bl);
      total++;
      if (q !== mq || r !== mr || z !== mz) begin
        bad++;
        $display("FAIL rand_result: %0d/%0d got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=%b",
                 n, dv, q, r, z, mq, mr, mz);
      end
      if (dv != 0) begin
        total++;
        if ((int'(q) * int'(dv) + int'(r)) != int'(n) || r >= dv) begin
          bad++;
          $display("FAIL rand_identity: %0d/%0d got q=%0d r=%0d, want q*d+r=n and r<d",
                   n, dv, q, r);
        end
      end
      total++;
      if (lat != ((dv == 0) ? 1 : W + 1) || us != 0 || bl != 0) begin
        bad++;
        $display("FAIL rand_timing: %0d/%0d got lat=%0d unstable=%0d busylow=%0d, want lat=%0d 0 0",
                 n, dv, lat, us, bl, (dv == 0) ? 1 : W + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
